// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage : write-back stage of an in-order pipeline.
//
// Accepts one MEM/WB instruction at a time. ALU and link (PC+4) results are
// written one cycle after acceptance. Loads wait for the data memory response
// (dmem_rvalid), extract and extend the addressed byte/half/word, and write
// one cycle after the response. A load that gets no response within
// TIMEOUT_CYC cycles is dropped and flagged with a one-cycle load_timeout.
//
// Parameters
//   TIMEOUT_CYC   cycles to wait for a load response (2..255)
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   mem_valid .. mem_Funct3      instruction from MEM/WB
//   dmem_rvalid, dmem_rdata      load response (aligned word)
//   RegWrite, WriteAddr,
//   WriteData                    register-file write port
//   wb_stall                     hold request to upstream (busy)
//   load_timeout                 one-cycle pulse when a load is aborted
//   misalign_err                 only with WB_MISALIGN_CHECK_EN defined:
//                                pulses in the WRITE cycle of a misaligned
//                                lh/lhu/lw, whose write is suppressed
//
// Optional feature macro: WB_MISALIGN_CHECK_EN
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_RegWrite,
  input  logic [1:0]  mem_MemtoReg,
  input  logic [4:0]  mem_rdAddr,
  input  logic [31:0] mem_ALUResult,
  input  logic [31:0] mem_PCPlus4,
  input  logic [2:0]  mem_Funct3,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        RegWrite,
  output logic [4:0]  WriteAddr,
  output logic [31:0] WriteData,
  output logic        wb_stall,
  output logic        load_timeout
`ifdef WB_MISALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    WRITE     = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;      // write allowed (RegWrite set and rd != 0)
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;          // byte offset of the load address
  logic        timeout_q, timeout_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [7:0]  cnt_inc;

`ifdef WB_MISALIGN_CHECK_EN
  logic        misalign_q, misalign_d;
  logic        misalign_now;

  // lb/lbu are always aligned; halves need addr[0]=0; everything else is a word
  always_comb begin
    misalign_now = 1'b0;
    case (mem_Funct3)
      3'b000, 3'b100: misalign_now = 1'b0;
      3'b001, 3'b101: misalign_now = mem_ALUResult[0];
      default:        misalign_now = (mem_ALUResult[1:0] != 2'b00);
    endcase
  end
`endif

  // Load data extraction from the aligned response word
  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (off_q)
      2'd0: ld_byte = dmem_rdata[7:0];
      2'd1: ld_byte = dmem_rdata[15:8];
      2'd2: ld_byte = dmem_rdata[23:16];
      2'd3: ld_byte = dmem_rdata[31:24];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  assign cnt_inc = cnt_q + 8'd1;

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = wr_en_q;
    funct3_d  = funct3_q;
    off_d     = off_q;
    timeout_d = 1'b0;
`ifdef WB_MISALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          wr_addr_d = mem_rdAddr;
          wr_en_d   = mem_RegWrite && (mem_rdAddr != 5'd0);
          if (mem_MemtoReg == 2'b01) begin
            funct3_d = mem_Funct3;
            off_d    = mem_ALUResult[1:0];
            cnt_d    = 8'd0;
            state_d  = WAIT_LOAD;
`ifdef WB_MISALIGN_CHECK_EN
            misalign_d = misalign_now;
`endif
          end else begin
            // 11 is reserved and behaves like 00 (ALU)
            wr_data_d = (mem_MemtoReg == 2'b10) ? mem_PCPlus4 : mem_ALUResult;
            state_d   = WRITE;
`ifdef WB_MISALIGN_CHECK_EN
            misalign_d = 1'b0;
`endif
          end
        end
      end
      WAIT_LOAD: begin
        // A response arriving on the last allowed cycle still wins
        if (dmem_rvalid) begin
          wr_data_d = ld_data;
          state_d   = WRITE;
        end else if (cnt_inc == TIMEOUT_LIM) begin
          cnt_d     = 8'd0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      wr_addr_q <= 5'd0;
      wr_data_q <= 32'd0;
      wr_en_q   <= 1'b0;
      funct3_q  <= 3'd0;
      off_q     <= 2'd0;
      timeout_q <= 1'b0;
`ifdef WB_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      funct3_q  <= funct3_d;
      off_q     <= off_d;
      timeout_q <= timeout_d;
`ifdef WB_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign WriteAddr    = wr_addr_q;
  assign WriteData    = wr_data_q;
  assign wb_stall     = (state_q != IDLE);
  assign load_timeout = timeout_q;
`ifdef WB_MISALIGN_CHECK_EN
  assign RegWrite     = (state_q == WRITE) && wr_en_q && !misalign_q;
  assign misalign_err = (state_q == WRITE) && misalign_q;
`else
  assign RegWrite     = (state_q == WRITE) && wr_en_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage : self-checking bench for wb_stage (TIMEOUT_CYC = 4).
// Expected writes/timeouts are queued when an instruction is issued and
// compared by a monitor whenever the DUT writes or pulses load_timeout.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_RegWrite;
  logic [1:0]  mem_MemtoReg;
  logic [4:0]  mem_rdAddr;
  logic [31:0] mem_ALUResult, mem_PCPlus4;
  logic [2:0]  mem_Funct3;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        RegWrite;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic        wb_stall, load_timeout;
`ifdef WB_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  wb_stage #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite),
    .mem_MemtoReg(mem_MemtoReg), .mem_rdAddr(mem_rdAddr),
    .mem_ALUResult(mem_ALUResult), .mem_PCPlus4(mem_PCPlus4),
    .mem_Funct3(mem_Funct3), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .wb_stall(wb_stall), .load_timeout(load_timeout)
`ifdef WB_MISALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        to;     // 1 = expect a timeout pulse, 0 = expect a write
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference load extraction, written with shifts rather than selects
  function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] sb_w, sh_w;
    sb_w = w >> (8 * int'(off));
    sh_w = w >> (off[1] ? 16 : 0);
    case (f3)
      3'b000:  return {{24{sb_w[7]}}, sb_w[7:0]};
      3'b100:  return sb_w & 32'h0000_00FF;
      3'b001:  return {{16{sh_w[15]}}, sh_w[15:0]};
      3'b101:  return sh_w & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  function automatic bit misal(input logic [2:0] f3, input logic [1:0] off);
`ifdef WB_MISALIGN_CHECK_EN
    if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
    if (f3 == 3'b001 || f3 == 3'b101) return off[0];
    return off != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // Scoreboard monitor
  exp_t m_e;
  always @(negedge clk) begin
    if (!rst && (RegWrite === 1'b1 || load_timeout === 1'b1)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", {30'd0, RegWrite, load_timeout}, 32'd0);
      end else begin
        m_e = sb.pop_front();
        check("sb_kind", {31'd0, load_timeout}, {31'd0, m_e.to});
        if (!m_e.to) begin
          check("sb_addr", {27'd0, WriteAddr}, {27'd0, m_e.addr});
          check("sb_data", WriteData, m_e.data);
        end
      end
    end
  end

  task automatic do_alu(input logic rw, input logic [1:0] mtr, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] pc);
    logic [31:0] exp_d;
    logic        exp_we;
    exp_d  = (mtr == 2'b10) ? pc : alu;
    exp_we = rw && (rd != 5'd0);
    if (exp_we) sb.push_back('{to: 1'b0, addr: rd, data: exp_d});
    $display("txn alu rw=%0d mtr=%0d rd=%0d exp_data=0x%08h", rw, mtr, rd, exp_d);
    @(negedge clk);
    mem_valid = 1'b1; mem_RegWrite = rw; mem_MemtoReg = mtr; mem_rdAddr = rd;
    mem_ALUResult = alu; mem_PCPlus4 = pc; mem_Funct3 = 3'b010;
    @(negedge clk);
    mem_valid = 1'b0;
    check("alu_we", {31'd0, RegWrite}, {31'd0, exp_we});
    check("alu_addr", {27'd0, WriteAddr}, {27'd0, rd});
    check("alu_data", WriteData, exp_d);
    check("alu_stall", {31'd0, wb_stall}, 32'd1);
    @(negedge clk);
    check("alu_we_after", {31'd0, RegWrite}, 32'd0);
    check("alu_stall_after", {31'd0, wb_stall}, 32'd0);
  endtask

  // delay = WAIT_LOAD cycle (1..TO) in which rvalid arrives; 0 = never
  task automatic do_load(input logic rw, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] off, input logic [31:0] word,
                         input int delay, input bit poke);
    logic [31:0] exp_d;
    logic        exp_we;
    int          n;
    exp_d  = ld_model(f3, off, word);
    exp_we = rw && (rd != 5'd0) && !misal(f3, off);
    if (delay == 0) sb.push_back('{to: 1'b1, addr: 5'd0, data: 32'd0});
    else if (exp_we) sb.push_back('{to: 1'b0, addr: rd, data: exp_d});
    $display("txn load f3=%0d rd=%0d off=%0d word=0x%08h delay=%0d exp_data=0x%08h",
             f3, rd, off, word, delay, exp_d);
    @(negedge clk);
    mem_valid = 1'b1; mem_RegWrite = rw; mem_MemtoReg = 2'b01; mem_rdAddr = rd;
    mem_ALUResult = 32'h0000_2000 | {30'd0, off}; mem_Funct3 = f3;
    @(negedge clk);
    mem_valid = 1'b0;
    n = (delay == 0) ? TO : delay;
    for (int k = 1; k <= n; k++) begin
      check("ld_stall", {31'd0, wb_stall}, 32'd1);
      if (poke && k == 1) begin
        // Must be ignored: the stage is busy
        mem_valid = 1'b1; mem_RegWrite = 1'b1; mem_MemtoReg = 2'b00;
        mem_rdAddr = 5'd9; mem_ALUResult = 32'h0000_DEAD;
      end
      if (k == delay) begin
        dmem_rvalid = 1'b1; dmem_rdata = word;
      end
      @(negedge clk);
      mem_valid = 1'b0;
      dmem_rvalid = 1'b0; dmem_rdata = $urandom;
    end
    if (delay != 0) begin
      check("ld_we", {31'd0, RegWrite}, {31'd0, exp_we});
      check("ld_addr", {27'd0, WriteAddr}, {27'd0, rd});
      check("ld_data", WriteData, exp_d);
      check("ld_stall_wr", {31'd0, wb_stall}, 32'd1);
      @(negedge clk);
      check("ld_we_after", {31'd0, RegWrite}, 32'd0);
      check("ld_stall_after", {31'd0, wb_stall}, 32'd0);
    end else begin
      check("to_pulse", {31'd0, load_timeout}, 32'd1);
      check("to_stall", {31'd0, wb_stall}, 32'd0);
      check("to_we", {31'd0, RegWrite}, 32'd0);
      @(negedge clk);
      check("to_pulse_once", {31'd0, load_timeout}, 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, {31'd0, RegWrite}, 32'd0);
    check({tag, "_addr"}, {27'd0, WriteAddr}, 32'd0);
    check({tag, "_data"}, WriteData, 32'd0);
    check({tag, "_stall"}, {31'd0, wb_stall}, 32'd0);
    check({tag, "_to"}, {31'd0, load_timeout}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_RegWrite = 1'b0; mem_MemtoReg = 2'b00;
    mem_rdAddr = 5'd0; mem_ALUResult = 32'd0; mem_PCPlus4 = 32'd0; mem_Funct3 = 3'd0;
    dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Non-load results
    do_alu(1'b1, 2'b00, 5'd5, 32'h0000_1234, 32'h0000_0040);
    do_alu(1'b1, 2'b10, 5'd0, 32'h0000_5555, 32'h0000_0104);   // jal rd=0
    do_alu(1'b1, 2'b10, 5'd1, 32'h0000_7777, 32'h0000_2000);   // jal rd=1
    do_alu(1'b1, 2'b11, 5'd9, 32'h0000_CAFE, 32'h0000_0008);   // reserved -> ALU
    do_alu(1'b0, 2'b00, 5'd4, 32'hA5A5_0001, 32'h0000_0000);   // no RegWrite

    // Loads; delay TO is the rvalid-vs-timeout boundary
    do_load(1'b1, 5'd3, 3'b000, 2'd2, 32'h0080_0000, TO, 1'b0);
    do_load(1'b1, 5'd3, 3'b100, 2'd2, 32'h0080_0000, 2, 1'b0);
    do_load(1'b1, 5'd7, 3'b101, 2'd2, 32'hBEEF_0000, 1, 1'b0);
    do_load(1'b1, 5'd7, 3'b001, 2'd2, 32'hBEEF_0000, 1, 1'b0);
    do_load(1'b1, 5'd8, 3'b000, 2'd0, 32'h11F2_7F83, 3, 1'b0);
    do_load(1'b1, 5'd8, 3'b100, 2'd1, 32'h11F2_7F83, 1, 1'b0);
    do_load(1'b1, 5'd8, 3'b000, 2'd3, 32'h91F2_7F83, 1, 1'b0);
    do_load(1'b1, 5'd8, 3'b001, 2'd0, 32'h11F2_7F83, 1, 1'b0);
    do_load(1'b1, 5'd10, 3'b010, 2'd0, 32'h8765_4321, 2, 1'b1);  // poke ignored
    do_load(1'b1, 5'd10, 3'b010, 2'd2, 32'h1357_9BDF, 1, 1'b0);
    do_load(1'b1, 5'd11, 3'b001, 2'd1, 32'h0000_8001, 1, 1'b0);
    do_load(1'b1, 5'd12, 3'b011, 2'd0, 32'hCAFE_F00D, 1, 1'b0);
    do_load(1'b1, 5'd0, 3'b010, 2'd0, 32'h0BAD_0BAD, 1, 1'b0);   // rd=0
    do_load(1'b1, 5'd13, 3'b010, 2'd0, 32'h0000_0000, 0, 1'b0);  // timeout

    // rvalid while idle is ignored
    $display("txn stray rvalid in IDLE");
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("stray_stall", {31'd0, wb_stall}, 32'd0);
    @(negedge clk);
    check("stray_data", WriteData, 32'hCAFE_F00D ^ 32'hCAFE_F00D ^ 32'h0BAD_0BAD);

    // Reset during WAIT_LOAD drops the load
    $display("txn reset during WAIT_LOAD");
    @(negedge clk);
    mem_valid = 1'b1; mem_RegWrite = 1'b1; mem_MemtoReg = 2'b01; mem_rdAddr = 5'd14;
    mem_ALUResult = 32'h0000_3000; mem_Funct3 = 3'b010;
    @(negedge clk);
    mem_valid = 1'b0;
    check("rst_pre_stall", {31'd0, wb_stall}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("rst_wait");
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check_all_zero("rst_rvalid");
    @(negedge clk);
    check_all_zero("rst_after");

    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, meaning the cycle limit waiting for a load response (range 2..255).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port mem_valid  input  1  MEM/WB instruction present this cycle.
REQ-005 SHALL have port mem_RegWrite  input  1  instruction writes rd.
REQ-006 SHALL have port mem_MemtoReg  input  2  result source: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as 00).
REQ-007 SHALL have port mem_rdAddr  input  5  destination register.
REQ-008 SHALL have port mem_ALUResult  input  32  ALU result or load byte address.
REQ-009 SHALL have port mem_PCPlus4  input  32  link value.
REQ-010 SHALL have port mem_Funct3  input  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; others treated as lw.
REQ-011 SHALL have port dmem_rvalid  input  1  load data valid.
REQ-012 SHALL have port dmem_rdata  input  32  aligned word read from data memory.
REQ-013 SHALL have port RegWrite  output  1  register-file write enable.
REQ-014 SHALL have port WriteAddr  output  5  register-file write address.
REQ-015 SHALL have port WriteData  output  32  register-file write data.
REQ-016 SHALL have port wb_stall  output  1  upstream hold request.
REQ-017 SHALL have port load_timeout  output  1  one-cycle pulse on aborted load.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT_LOAD, WRITE.
REQ-019 IDLE: mem_valid with MemtoReg!=01 SHALL go to WRITE, registering the address and the selected data.
REQ-020 IDLE: mem_valid with MemtoReg=01 SHALL go to WAIT_LOAD, registering rdAddr, Funct3, ALUResult[1:0], RegWrite; counter cleared.
REQ-021 WAIT_LOAD: dmem_rvalid SHALL register the extracted/extended data and go to WRITE.
REQ-022 WAIT_LOAD: counter SHALL increment each cycle without rvalid; at TIMEOUT_CYC it SHALL pulse load_timeout for one cycle, go to IDLE, and not write.
REQ-023 WRITE: RegWrite SHALL be high exactly one cycle, then IDLE; WRITE SHALL NOT accept a new instruction.
REQ-024 RegWrite SHALL be forced 0 when the registered rd=0 or mem_RegWrite was 0; WriteAddr/WriteData still update.
REQ-025 wb_stall SHALL be high in WAIT_LOAD and WRITE, low in IDLE (combinational from state).
REQ-026 mem_valid while wb_stall=1 SHALL be ignored; upstream holds its instruction.
REQ-027 dmem_rvalid outside WAIT_LOAD SHALL be ignored.
REQ-028 Byte select: lb/lbu use rdata[8*a+7:8*a], a=addr[1:0]; lh/lhu use half addr[1]; lb/lh sign-extend, lbu/lhu zero-extend.
REQ-029 Non-load latency: accept edge to RegWrite high = 1 cycle; load: rvalid edge to RegWrite high = 1 cycle.
REQ-030 rvalid in the same cycle the counter would reach TIMEOUT_CYC SHALL win; data written, no timeout pulse.

Reset
REQ-031 rst SHALL force IDLE, counter 0, RegWrite 0, WriteAddr 0, WriteData 0, wb_stall 0, load_timeout 0.
REQ-032 rst during WAIT_LOAD or WRITE SHALL drop the pending instruction with no write.

Configuration
REQ-033 Macro WB_MISALIGN_CHECK_EN defined: lh/lhu with addr[0]=1 or lw with addr[1:0]!=0 SHALL suppress RegWrite, still pass through WRITE and pulse an extra output misalign_err (1 bit) that cycle.
REQ-034 Macro undefined: misalign_err port SHALL not exist; lh/lhu SHALL ignore addr[0], lw SHALL ignore addr[1:0].

Verification
REQ-035 ALU op rd=5, ALUResult=0x1234 -> next cycle RegWrite=1, WriteAddr=5, WriteData=0x00001234, one cycle only.
REQ-036 lb rd=3 addr[1:0]=2, rvalid after 4 cycles rdata=0x00800000 -> wb_stall high 5 cycles, WriteData=0xFFFFFF80.
REQ-037 lhu rd=7 addr[1:0]=2, rdata=0xBEEF0000 -> WriteData=0x0000BEEF; lh same -> 0xFFFFBEEF.
REQ-038 Load with TIMEOUT_CYC=4, no rvalid -> load_timeout pulse once, no RegWrite, back in IDLE, wb_stall low.
REQ-039 rd=0 jal (MemtoReg=10, PCPlus4=0x104) -> RegWrite stays 0, WriteData=0x104.
REQ-040 rst asserted in WAIT_LOAD then rvalid -> no write, all outputs 0.
